// File: rtl/osd_key_queue.sv
// osd_key_queue
// Buffers decoded UKNC keycodes from the keyboard decoder and hands each one either to
// the OSD menu (press_btn/keycode/read_kbd pulse handshake) or to the CPU keyboard port
// (cpu_valid/cpu_ready). A dedicated hot key is never queued. Instead it produces a
// 2-cycle osd_en pulse that toggles the OSD.
//
// Ports:
//  clk        in   system clock, all logic on posedge
//  rst        in   asynchronous, active-high reset
//  key_valid  in   1-cycle strobe, key_code valid
//  key_code   in   [7:0] keycode from decoder
//  osd_on     in   OSD currently displayed
//  osd_en     out  OSD toggle request (2-cycle pulse)
//  press_btn  out  key presented to OSD
//  keycode    out  [7:0] keycode presented to OSD / CPU
//  read_kbd   in   OSD consumed the key
//  cpu_valid  out  key presented to CPU
//  cpu_ready  in   CPU accepts key when cpu_valid & cpu_ready
//  overflow   out  sticky: a key was dropped because the FIFO was full
//  clr_ovf    in   clears overflow
module osd_key_queue #(
    parameter int         DEPTH  = 8,
    parameter logic [7:0] HOTKEY = 8'o13,
    parameter int         GAP    = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       key_valid,
    input  logic [7:0] key_code,
    input  logic       osd_on,
    output logic       osd_en,
    output logic       press_btn,
    output logic [7:0] keycode,
    input  logic       read_kbd,
    output logic       cpu_valid,
    input  logic       cpu_ready,
    output logic       overflow,
    input  logic       clr_ovf
);

    localparam int AW = $clog2(DEPTH);
    localparam int GW = $clog2(GAP);

    typedef enum logic [1:0] {IDLE, PRES_OSD, GAP_OSD, PRES_CPU} state_t;

    logic [7:0]  mem_r [DEPTH];
    logic [AW-1:0] wr_ptr_r, rd_ptr_r;
    logic [AW:0] count_r;
    state_t      state_r, state_nxt_s;
    logic [GW-1:0] gap_cnt_r, gap_cnt_nxt_s;
    logic        press_btn_r, press_nxt_s;
    logic        cpu_valid_r, cpu_nxt_s;
    logic [7:0]  keycode_r;
    logic        osd_en_r, hot_cnt_r;
    logic        overflow_r;
    logic        osd_on_d_r;

    logic flush_s, hot_s, empty_s, full_s, pop_s, enq_s, drop_s;

    // Any osd_on edge empties the queue so keys never cross between menu and CPU.
    assign flush_s = osd_on ^ osd_on_d_r;
    assign hot_s   = key_valid & (key_code == HOTKEY);
    assign empty_s = (count_r == {(AW+1){1'b0}});
    assign full_s  = (count_r == (AW+1)'(DEPTH));
    // A pop in the same cycle frees a slot; a flush always leaves room for the new key.
    assign enq_s   = key_valid & ~hot_s & (~full_s | pop_s | flush_s);
    assign drop_s  = key_valid & ~hot_s & full_s & ~pop_s & ~flush_s;

    // Next-state and next-output logic of the presentation FSM.
    always_comb begin
        state_nxt_s   = state_r;
        gap_cnt_nxt_s = gap_cnt_r;
        press_nxt_s   = 1'b0;
        cpu_nxt_s     = 1'b0;
        pop_s         = 1'b0;
        case (state_r)
            IDLE: begin
                // No pop during a flush: the head is being discarded this cycle.
                if (!empty_s && !flush_s) begin
                    pop_s = 1'b1;
                    if (osd_on) begin
                        state_nxt_s = PRES_OSD;
                        press_nxt_s = 1'b1;
                    end else begin
                        state_nxt_s = PRES_CPU;
                        cpu_nxt_s   = 1'b1;
                    end
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            PRES_OSD: begin
                if (!osd_on) begin
                    state_nxt_s = IDLE;           // menu closed: key discarded
                end else if (read_kbd) begin
                    state_nxt_s   = GAP_OSD;
                    gap_cnt_nxt_s = {GW{1'b0}};
                end else begin
                    press_nxt_s = 1'b1;
                end
            end
            GAP_OSD: begin
                if (gap_cnt_r == GW'(GAP - 1)) begin
                    state_nxt_s = IDLE;
                end else begin
                    gap_cnt_nxt_s = gap_cnt_r + GW'(1);
                end
            end
            PRES_CPU: begin
                if (cpu_ready) begin
                    state_nxt_s = IDLE;
                end else begin
                    cpu_nxt_s = 1'b1;
                end
            end
            default: begin
                state_nxt_s = IDLE;
            end
        endcase
    end

    // FSM state, registered handshake outputs and presented keycode.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r     <= IDLE;
            gap_cnt_r   <= {GW{1'b0}};
            press_btn_r <= 1'b0;
            cpu_valid_r <= 1'b0;
            keycode_r   <= 8'd0;
        end else begin
            state_r     <= state_nxt_s;
            gap_cnt_r   <= gap_cnt_nxt_s;
            press_btn_r <= press_nxt_s;
            cpu_valid_r <= cpu_nxt_s;
            if (pop_s) begin
                keycode_r <= mem_r[rd_ptr_r];
            end else begin
                keycode_r <= keycode_r;
            end
        end
    end

    // FIFO storage; a flush restarts writing at slot 0.
    always_ff @(posedge clk) begin
        if (enq_s) begin
            mem_r[flush_s ? {AW{1'b0}} : wr_ptr_r] <= key_code;
        end
    end

    // FIFO pointers and occupancy.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
            count_r  <= {(AW+1){1'b0}};
        end else if (flush_s) begin
            rd_ptr_r <= {AW{1'b0}};
            wr_ptr_r <= enq_s ? AW'(1) : {AW{1'b0}};
            count_r  <= enq_s ? (AW+1)'(1) : {(AW+1){1'b0}};
        end else begin
            if (enq_s) wr_ptr_r <= wr_ptr_r + AW'(1);
            if (pop_s) rd_ptr_r <= rd_ptr_r + AW'(1);
            case ({enq_s, pop_s})
                2'b10:   count_r <= count_r + (AW+1)'(1);
                2'b01:   count_r <= count_r - (AW+1)'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    // Hot-key pulse: 2 cycles high, new hot keys ignored while it is high.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            osd_en_r  <= 1'b0;
            hot_cnt_r <= 1'b0;
        end else if (osd_en_r) begin
            osd_en_r  <= ~hot_cnt_r;
            hot_cnt_r <= ~hot_cnt_r;
        end else if (hot_s) begin
            osd_en_r  <= 1'b1;
            hot_cnt_r <= 1'b0;
        end else begin
            osd_en_r  <= 1'b0;
            hot_cnt_r <= 1'b0;
        end
    end

    // Sticky overflow; a drop wins over a simultaneous clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            overflow_r <= 1'b0;
        end else if (drop_s) begin
            overflow_r <= 1'b1;
        end else if (clr_ovf) begin
            overflow_r <= 1'b0;
        end else begin
            overflow_r <= overflow_r;
        end
    end

    // Delayed osd_on for edge detection.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            osd_on_d_r <= 1'b0;
        end else begin
            osd_on_d_r <= osd_on;
        end
    end

    assign osd_en    = osd_en_r;
    assign press_btn = press_btn_r;
    assign cpu_valid = cpu_valid_r;
    assign keycode   = keycode_r;
    assign overflow  = overflow_r;

endmodule

// File: tb/tb_osd_key_queue.sv
// Self-checking bench for osd_key_queue: a queue-based reference model checked every
// cycle, plus hand-computed expectations for the directed scenarios.
module tb_osd_key_queue;

    localparam int         DEPTH  = 8;
    localparam int         GAP    = 2;
    localparam logic [7:0] HOTKEY = 8'o13;

    logic       clk = 1'b0;
    logic       rst, key_valid, osd_on, read_kbd, cpu_ready, clr_ovf;
    logic [7:0] key_code, keycode;
    logic       osd_en, press_btn, cpu_valid, overflow;

    int tests = 0;
    int fails = 0;

    osd_key_queue #(.DEPTH(DEPTH), .HOTKEY(HOTKEY), .GAP(GAP)) dut (
        .clk(clk), .rst(rst), .key_valid(key_valid), .key_code(key_code),
        .osd_on(osd_on), .osd_en(osd_en), .press_btn(press_btn), .keycode(keycode),
        .read_kbd(read_kbd), .cpu_valid(cpu_valid), .cpu_ready(cpu_ready),
        .overflow(overflow), .clr_ovf(clr_ovf)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a queue of waiting keys, who holds the presented key, and countdowns.
    logic [7:0] m_q [$];
    bit         m_osd, m_cpu, m_ovf, m_prev_on;
    int         m_gap, m_hot;
    logic [7:0] m_key;

    always @(posedge clk) begin
        bit flush, hot, idle, pop, fits, enq, drop;
        if (rst) begin
            m_q.delete();
            m_osd = 0; m_cpu = 0; m_ovf = 0; m_prev_on = 0;
            m_gap = 0; m_hot = 0; m_key = 8'd0;
        end else begin
            flush = (osd_on != m_prev_on);
            hot   = key_valid && (key_code == HOTKEY);
            idle  = !m_osd && !m_cpu && (m_gap == 0);
            pop   = idle && (m_q.size() > 0) && !flush;
            fits  = (m_q.size() < DEPTH) || pop || flush;
            enq   = key_valid && !hot && fits;
            drop  = key_valid && !hot && !fits;
            if (m_osd) begin
                if (!osd_on) m_osd = 0;
                else if (read_kbd) begin m_osd = 0; m_gap = GAP; end
            end else if (m_gap > 0) begin
                m_gap--;
            end
            if (m_cpu && cpu_ready) m_cpu = 0;
            if (pop) begin
                m_key = m_q.pop_front();
                if (osd_on) m_osd = 1; else m_cpu = 1;
            end
            if (flush) m_q.delete();
            if (enq) m_q.push_back(key_code);
            if (m_hot > 0) m_hot--;
            else if (hot) m_hot = 2;
            if (drop) m_ovf = 1;
            else if (clr_ovf) m_ovf = 0;
            m_prev_on = osd_on;
        end
        #1;
        chk("cyc_press_btn", press_btn, m_osd);
        chk("cyc_cpu_valid", cpu_valid, m_cpu);
        chk("cyc_keycode", keycode, m_key);
        chk("cyc_osd_en", osd_en, (m_hot > 0));
        chk("cyc_overflow", overflow, m_ovf);
    end

    task automatic step();
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b1; key_valid = 1'b0; key_code = 8'd0; osd_on = 1'b0;
        read_kbd = 1'b0; cpu_ready = 1'b0; clr_ovf = 1'b0;
        repeat (3) step();
        chk("rst_press", press_btn, 8'd0);
        chk("rst_cpu_valid", cpu_valid, 8'd0);
        chk("rst_keycode", keycode, 8'd0);
        chk("rst_osd_en", osd_en, 8'd0);
        chk("rst_overflow", overflow, 8'd0);
        rst = 1'b0;
        step();

        // OSD key with handshake and gap
        osd_on = 1'b1;
        repeat (2) step();
        key_valid = 1'b1; key_code = 8'o154;
        step();
        key_valid = 1'b0;
        chk("osd_lat1_press", press_btn, 8'd0);
        step();
        chk("osd_lat2_press", press_btn, 8'd1);
        chk("osd_keycode", keycode, 8'o154);
        read_kbd = 1'b1;
        step();
        read_kbd = 1'b0;
        chk("osd_ack_press", press_btn, 8'd0);
        step();
        chk("osd_gap1_press", press_btn, 8'd0);
        step();
        chk("osd_gap2_press", press_btn, 8'd0);

        // CPU path, backpressure, ordering
        osd_on = 1'b0;
        repeat (2) step();
        key_valid = 1'b1; key_code = 8'o101;
        step();
        key_code = 8'o102;
        step();
        key_valid = 1'b0;
        repeat (5) step();
        chk("cpu_hold_valid", cpu_valid, 8'd1);
        chk("cpu_hold_key", keycode, 8'o101);
        cpu_ready = 1'b1;
        step();
        cpu_ready = 1'b0;
        chk("cpu_accept_valid", cpu_valid, 8'd0);
        step();
        chk("cpu_second_valid", cpu_valid, 8'd1);
        chk("cpu_second_key", keycode, 8'o102);
        cpu_ready = 1'b1;
        step();
        cpu_ready = 1'b0;
        step();

        // Hot key
        key_valid = 1'b1; key_code = HOTKEY;
        step();
        key_valid = 1'b0;
        chk("hot_c1", osd_en, 8'd1);
        step();
        chk("hot_c2", osd_en, 8'd1);
        step();
        chk("hot_c3", osd_en, 8'd0);
        chk("hot_no_cpu", cpu_valid, 8'd0);
        chk("hot_no_press", press_btn, 8'd0);

        // Fill to overflow: 1 presented + 8 stored, the 10th key is dropped
        for (int i = 0; i < 10; i++) begin
            key_valid = 1'b1; key_code = 8'h40 + 8'(i);
            step();
            if (i == 8) chk("ovf_not_yet", overflow, 8'd0);
        end
        chk("ovf_set", overflow, 8'd1);
        key_code = 8'h4A; clr_ovf = 1'b1;
        step();
        key_valid = 1'b0; clr_ovf = 1'b0;
        chk("ovf_drop_beats_clr", overflow, 8'd1);
        clr_ovf = 1'b1;
        step();
        clr_ovf = 1'b0;
        chk("ovf_cleared", overflow, 8'd0);
        cpu_ready = 1'b1;
        for (int i = 0; i < 9; i++) begin
            chk("drain_valid", cpu_valid, 8'd1);
            chk("drain_key", keycode, 8'h40 + 8'(i));
            step();
            step();
        end
        chk("drain_empty", cpu_valid, 8'd0);
        cpu_ready = 1'b0;

        // osd_on falls while a key is presented with 3 queued
        osd_on = 1'b1;
        repeat (2) step();
        for (int i = 0; i < 4; i++) begin
            key_valid = 1'b1; key_code = 8'o60 + 8'(i);
            step();
        end
        key_valid = 1'b0;
        chk("fall_pres_press", press_btn, 8'd1);
        chk("fall_pres_key", keycode, 8'o60);
        osd_on = 1'b0;
        step();
        chk("fall_press_drop", press_btn, 8'd0);
        repeat (4) step();
        chk("fall_no_cpu", cpu_valid, 8'd0);

        // Asynchronous reset during a CPU presentation
        key_valid = 1'b1; key_code = 8'o70;
        step();
        key_code = 8'o71;
        step();
        key_valid = 1'b0;
        chk("arst_pre_valid", cpu_valid, 8'd1);
        #2 rst = 1'b1;
        #1;
        chk("arst_valid", cpu_valid, 8'd0);
        chk("arst_key", keycode, 8'd0);
        step();
        rst = 1'b0;
        step();
        key_valid = 1'b1; key_code = 8'o72;
        step();
        key_valid = 1'b0;
        step();
        chk("arst_after_valid", cpu_valid, 8'd1);
        chk("arst_after_key", keycode, 8'o72);
        cpu_ready = 1'b1;
        step();
        cpu_ready = 1'b0;
        repeat (2) step();
        chk("arst_queue_cleared", cpu_valid, 8'd0);

        // Mixed traffic checked by the model
        for (int i = 0; i < 300; i++) begin
            key_valid = 1'($urandom_range(0, 1));
            key_code  = ($urandom_range(0, 7) == 0) ? HOTKEY : 8'($urandom_range(0, 255));
            read_kbd  = ($urandom_range(0, 2) == 0);
            cpu_ready = ($urandom_range(0, 3) == 0);
            clr_ovf   = ($urandom_range(0, 15) == 0);
            if ($urandom_range(0, 40) == 0) osd_on = ~osd_on;
            step();
        end
        key_valid = 1'b0; read_kbd = 1'b0; cpu_ready = 1'b0; clr_ovf = 1'b0;
        repeat (2) step();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
